// File: rtl/msb_pkg.sv
// rtl/msb_pkg.sv - shared defaults and pipeline entry type for the L2 response controller
package msb_pkg;

    localparam int NSTRMS = 64;
    localparam int NCL    = 16;
    localparam int SID_W  = $clog2(NSTRMS);
    localparam int CLID_W = $clog2(NCL);

    // One URAM-read-to-L1-write pipeline slot at the default sizes.
    typedef struct packed {
        logic              v;
        logic [SID_W-1:0]  sid;
        logic [CLID_W-1:0] clid;
    } pipe_ent_t;

endpackage

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - n-way round-robin arbiter with one-hot grant
// Ports: clk, reset (async active-low), i_req[n] requests,
//        o_gnt[n] one-hot grant, o_gnt_v any grant, o_gnt_idx granted index.
module rr_arb #(
    parameter int n = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [n-1:0]         i_req,
    output logic [n-1:0]         o_gnt,
    output logic                 o_gnt_v,
    output logic [$clog2(n)-1:0] o_gnt_idx
);
    localparam int iw = $clog2(n);

    // Index that has highest priority this cycle (last grant + 1).
    logic [iw-1:0] r_ptr;
    logic [iw-1:0] w_idx;
    int            w_j;

    always_comb begin
        o_gnt     = '0;
        o_gnt_v   = 1'b0;
        o_gnt_idx = '0;
        w_j       = 0;
        w_idx     = '0;
        for (int k = 0; k < n; k++) begin
            w_j = int'(r_ptr) + k;
            if (w_j >= n) w_j = w_j - n;
            w_idx = iw'(w_j);
            if (!o_gnt_v && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                o_gnt_v      = 1'b1;
                o_gnt_idx    = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (o_gnt_v) begin
            r_ptr <= (o_gnt_idx == iw'(n - 1)) ? '0 : o_gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/l2_rsp_ctrl.sv
// rtl/l2_rsp_ctrl.sv - per-stream cacheline fetch control: URAM read -> L1 write -> response
// Ports: clk, reset (async active-low);
//        i_req_v/i_req_r  per-stream cacheline request handshake;
//        o_rsp_v/o_rsp_r  per-stream "landed in L1" response handshake;
//        i_rst_v/i_rst_r  per-stream functional reset handshake;
//        o_ur_re/o_ur_sid/o_ur_clid  URAM read pulse and address;
//        o_wr_en/o_wr_sid/o_wr_clid  L1 write pulse and address (lat cycles after read).
module l2_rsp_ctrl
    import msb_pkg::*;
#(
    parameter int nstrms = NSTRMS,
    parameter int ncl    = NCL,
    parameter int lat    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [nstrms-1:0]         i_req_v,
    output logic [nstrms-1:0]         i_req_r,
    output logic [nstrms-1:0]         o_rsp_v,
    input  logic [nstrms-1:0]         o_rsp_r,
    input  logic [nstrms-1:0]         i_rst_v,
    output logic [nstrms-1:0]         i_rst_r,
    output logic                      o_ur_re,
    output logic [$clog2(nstrms)-1:0] o_ur_sid,
    output logic [$clog2(ncl)-1:0]    o_ur_clid,
    output logic                      o_wr_en,
    output logic [$clog2(nstrms)-1:0] o_wr_sid,
    output logic [$clog2(ncl)-1:0]    o_wr_clid
);
    localparam int sid_width  = $clog2(nstrms);
    localparam int clid_width = $clog2(ncl);

    // Same layout as pipe_ent_t, sized for this instance's parameters.
    typedef struct packed {
        logic                  v;
        logic [sid_width-1:0]  sid;
        logic [clid_width-1:0] clid;
    } ent_t;

    logic [clid_width-1:0] r_clid [nstrms];
    logic [nstrms-1:0]     r_infl;
    logic [nstrms-1:0]     r_pend;
    ent_t                  r_pipe [lat];

    logic [nstrms-1:0]     w_elig;
    logic [nstrms-1:0]     w_gnt;
    logic                  w_gnt_v;
    logic [sid_width-1:0]  w_gnt_idx;
    logic [nstrms-1:0]     w_rst_hs;
    logic [nstrms-1:0]     w_wr_dec;
    logic [clid_width-1:0] w_clid_nxt;
    ent_t                  w_ent;
    ent_t                  w_wr;

    // A stream in reset this cycle never competes, so reset wins a same-cycle clash.
    // Gating with reset keeps i_req_r low while the block is held in reset.
    assign w_elig = i_req_v & ~(r_infl | r_pend) & ~i_rst_v & {nstrms{reset}};

    rr_arb #(.n(nstrms)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .i_req     (w_elig),
        .o_gnt     (w_gnt),
        .o_gnt_v   (w_gnt_v),
        .o_gnt_idx (w_gnt_idx)
    );

    assign i_req_r  = w_gnt;
    assign i_rst_r  = ~r_infl;
    assign w_rst_hs = i_rst_v & ~r_infl;

    assign w_ent.v    = w_gnt_v;
    assign w_ent.sid  = w_gnt_v ? w_gnt_idx : '0;
    assign w_ent.clid = w_gnt_v ? r_clid[w_gnt_idx] : '0;
    assign w_clid_nxt = (r_clid[w_gnt_idx] == clid_width'(ncl - 1)) ? '0
                                                                      : r_clid[w_gnt_idx] + 1'b1;

    assign o_ur_re   = w_ent.v;
    assign o_ur_sid  = w_ent.sid;
    assign o_ur_clid = w_ent.clid;

    // Idle slots carry zero addresses, so the write outputs need no extra gating.
    assign w_wr      = r_pipe[lat-1];
    assign o_wr_en   = w_wr.v;
    assign o_wr_sid  = w_wr.sid;
    assign o_wr_clid = w_wr.clid;
    assign w_wr_dec  = w_wr.v ? (nstrms'(1) << w_wr.sid) : '0;

    assign o_rsp_v = r_pend;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < lat; k++) r_pipe[k] <= '0;
        end else begin
            r_pipe[0] <= w_ent;
            for (int k = 1; k < lat; k++) r_pipe[k] <= r_pipe[k-1];
        end
    end

    // Grant needs ~busy and a reset handshake needs ~inflight, so for any one
    // stream grant/write/reset never collide in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < nstrms; s++) r_clid[s] <= '0;
            r_infl <= '0;
            r_pend <= '0;
        end else begin
            for (int s = 0; s < nstrms; s++) begin
                if (w_rst_hs[s])   r_clid[s] <= '0;
                else if (w_gnt[s]) r_clid[s] <= w_clid_nxt;
            end
            r_infl <= (r_infl | w_gnt) & ~w_wr_dec;
            r_pend <= (r_pend & ~o_rsp_r & ~w_rst_hs) | w_wr_dec;
        end
    end

endmodule

// File: tb/tb_l2_rsp_ctrl.sv
// tb/tb_l2_rsp_ctrl.sv - self-checking bench for l2_rsp_ctrl
module tb_l2_rsp_ctrl;
    localparam int N   = 64;
    localparam int NCL = 16;
    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] i_req_v, i_req_r, o_rsp_v, o_rsp_r, i_rst_v, i_rst_r;
    logic         o_ur_re, o_wr_en;
    logic [5:0]   o_ur_sid, o_wr_sid;
    logic [3:0]   o_ur_clid, o_wr_clid;

    l2_rsp_ctrl dut (
        .clk(clk), .reset(reset),
        .i_req_v(i_req_v), .i_req_r(i_req_r),
        .o_rsp_v(o_rsp_v), .o_rsp_r(o_rsp_r),
        .i_rst_v(i_rst_v), .i_rst_r(i_rst_r),
        .o_ur_re(o_ur_re), .o_ur_sid(o_ur_sid), .o_ur_clid(o_ur_clid),
        .o_wr_en(o_wr_en), .o_wr_sid(o_wr_sid), .o_wr_clid(o_wr_clid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: stream counters plus a queue of scheduled L1 writes.
    typedef struct { int sid; int clid; int due; } wr_t;
    int  m_clid [N];
    bit  m_infl [N];
    bit  m_pend [N];
    int  m_ptr;
    int  cyc;
    wr_t wq [$];

    logic [N-1:0] obs_req_r, obs_rst_r, obs_rsp_v;
    logic         obs_ur_re, obs_wr_en;
    int           obs_ur_sid, obs_ur_clid, obs_wr_sid;

    localparam logic [N-1:0] ONES = '1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < N; s++) begin
            m_clid[s] = 0; m_infl[s] = 0; m_pend[s] = 0;
        end
        m_ptr = 0;
        wq.delete();
    endtask

    task automatic step(input logic [N-1:0] rq, input logic [N-1:0] rs, input logic [N-1:0] rr);
        int g;
        int sc;
        bit w;
        int wsid, wclid;
        bit pi [N];
        logic [N-1:0] e_req_r, e_rst_r, e_rsp_v;
        @(negedge clk);
        i_req_v = rq; i_rst_v = rs; o_rsp_r = rr;
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            sc = (m_ptr + k) % N;
            if (g < 0 && rq[sc] && !m_infl[sc] && !m_pend[sc] && !rs[sc]) g = sc;
        end
        e_req_r = '0;
        if (g >= 0) e_req_r[g] = 1'b1;
        for (int s = 0; s < N; s++) begin
            e_rst_r[s] = !m_infl[s];
            e_rsp_v[s] = m_pend[s];
        end
        w     = (wq.size() > 0) && (wq[0].due == cyc);
        wsid  = w ? wq[0].sid : 0;
        wclid = w ? wq[0].clid : 0;
        chk("req_r",   i_req_r,        e_req_r);
        chk("rst_r",   i_rst_r,        e_rst_r);
        chk("rsp_v",   o_rsp_v,        e_rsp_v);
        chk("ur_re",   64'(o_ur_re),   64'(g >= 0));
        chk("ur_sid",  64'(o_ur_sid),  64'(g >= 0 ? g : 0));
        chk("ur_clid", 64'(o_ur_clid), 64'(g >= 0 ? m_clid[g] : 0));
        chk("wr_en",   64'(o_wr_en),   64'(w));
        chk("wr_sid",  64'(o_wr_sid),  64'(wsid));
        chk("wr_clid", 64'(o_wr_clid), 64'(wclid));
        obs_req_r = i_req_r; obs_rst_r = i_rst_r; obs_rsp_v = o_rsp_v;
        obs_ur_re = o_ur_re; obs_ur_sid = int'(o_ur_sid); obs_ur_clid = int'(o_ur_clid);
        obs_wr_en = o_wr_en; obs_wr_sid = int'(o_wr_sid);
        @(posedge clk);
        for (int s = 0; s < N; s++) pi[s] = m_infl[s];
        for (int s = 0; s < N; s++) begin
            if (m_pend[s] && rr[s]) m_pend[s] = 0;
            if (rs[s] && !pi[s]) begin m_clid[s] = 0; m_pend[s] = 0; end
        end
        if (w) begin
            m_infl[wsid] = 0; m_pend[wsid] = 1;
            void'(wq.pop_front());
        end
        if (g >= 0) begin
            m_infl[g] = 1;
            wq.push_back('{g, m_clid[g], cyc + LAT});
            m_clid[g] = (m_clid[g] + 1) % NCL;
            m_ptr = (g + 1) % N;
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        i_req_v = '0; i_rst_v = '0; o_rsp_r = '0;
        #1;
        model_clear();
        chk("rst_wr_en",  64'(o_wr_en),  64'd0);
        chk("rst_ur_re",  64'(o_ur_re),  64'd0);
        chk("rst_rsp_v",  o_rsp_v,       64'd0);
        chk("rst_req_r",  i_req_r,       64'd0);
        chk("rst_rst_r",  i_rst_r,       ONES);
        chk("rst_ur_sid", 64'(o_ur_sid), 64'd0);
        chk("rst_wr_sid", 64'(o_wr_sid), 64'd0);
        @(negedge clk);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        int ng;
        logic [N-1:0] rq, rs, rr;
        reset = 1'b0; i_req_v = '0; i_rst_v = '0; o_rsp_r = '0;
        cyc = 0;
        model_clear();
        do_reset();

        // Single request on stream 5: grant now, write at +2, response at +3.
        step(N'(1) << 5, '0, '0);
        chk("s1_req_r5", 64'(obs_req_r[5]), 64'd1);
        chk("s1_clid",   64'(obs_ur_clid),  64'd0);
        step('0, '0, '0);
        step('0, '0, '0);
        chk("s1_wr_en",  64'(obs_wr_en),    64'd1);
        chk("s1_wr_sid", 64'(obs_wr_sid),   64'd5);
        step('0, '0, '0);
        chk("s1_rsp_v5", 64'(obs_rsp_v[5]), 64'd1);

        // Streams 0,1,2 together: back-to-back grants in order.
        for (int k = 0; k < 3; k++) begin
            step(N'(7), '0, ONES);
            chk("s2_ur_re",  64'(obs_ur_re),  64'd1);
            chk("s2_ur_sid", 64'(obs_ur_sid), 64'(k));
        end
        for (int k = 0; k < 5; k++) step('0, '0, ONES);

        // Stream 3 x17: clid wraps 15 -> 0, never regranted while responding.
        ng = 0;
        for (int k = 0; k < 120 && ng < 17; k++) begin
            step(N'(1) << 3, '0, ONES);
            if (obs_rsp_v[3]) chk("s3_noregrant", 64'(obs_req_r[3]), 64'd0);
            if (obs_ur_re) begin
                chk("s3_clid", 64'(obs_ur_clid), 64'(ng % NCL));
                ng++;
            end
        end
        chk("s3_count", 64'(ng), 64'd17);
        for (int k = 0; k < 5; k++) step('0, '0, ONES);

        // Stream 7 reset while inflight: stalled until the write lands.
        step(N'(1) << 7, '0, '0);
        chk("s4_grant", 64'(obs_req_r[7]), 64'd1);
        step('0, N'(1) << 7, '0);
        chk("s4_stall1", 64'(obs_rst_r[7]), 64'd0);
        step('0, N'(1) << 7, '0);
        chk("s4_stall2", 64'(obs_rst_r[7]), 64'd0);
        chk("s4_wr",     64'(obs_wr_en),    64'd1);
        step('0, N'(1) << 7, '0);
        chk("s4_accept", 64'(obs_rst_r[7]), 64'd1);
        chk("s4_pend",   64'(obs_rsp_v[7]), 64'd1);
        step('0, '0, '0);
        chk("s4_rsp_clr", 64'(obs_rsp_v[7]), 64'd0);
        step(N'(1) << 7, '0, '0);
        chk("s4_regrant", 64'(obs_req_r[7]), 64'd1);
        chk("s4_clid0",   64'(obs_ur_clid),  64'd0);
        for (int k = 0; k < 5; k++) step('0, '0, ONES);

        // Reset mid-pipeline: the pending write is dropped, pointer restarts at 0.
        step(N'(1) << 10, '0, '0);
        step('0, '0, '0);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step('0, '0, '0);
            chk("s5_nowr", 64'(obs_wr_en), 64'd0);
            chk("s5_rsp",  obs_rsp_v,      64'd0);
        end
        step((N'(1) << 20) | N'(1), '0, ONES);
        chk("s5_ptr0", 64'(obs_ur_sid), 64'd0);
        for (int k = 0; k < 5; k++) step('0, '0, ONES);

        // Request and reset on stream 9 together: reset wins, grant next cycle.
        step(N'(1) << 9, N'(1) << 9, ONES);
        chk("s6_nogrant", 64'(obs_req_r[9]), 64'd0);
        chk("s6_rst_r",   64'(obs_rst_r[9]), 64'd1);
        step(N'(1) << 9, '0, ONES);
        chk("s6_grant",   64'(obs_req_r[9]), 64'd1);

        // Randomized traffic against the model, with one reset part-way.
        for (int k = 0; k < 1500; k++) begin
            for (int s = 0; s < N; s++) begin
                rq[s] = ($urandom_range(0, 3) == 0);
                rs[s] = ($urandom_range(0, 40) == 0);
                rr[s] = ($urandom_range(0, 1) == 1);
            end
            step(rq, rs, rr);
            if (k == 700) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/l2_rsp_ctrl.md
L2_RSP_CTRL -- requirements
Module: l2_rsp_ctrl

Interface
REQ-001 SHALL have parameter nstrms, default 64, number of streams.
REQ-002 SHALL have parameter ncl, default 16, cachelines per stream in L1.
REQ-003 SHALL have parameter lat, default 2, fixed URAM read latency in cycles (>=1).
REQ-004 SHALL derive sid_width=$clog2(nstrms) and clid_width=$clog2(ncl).
REQ-005 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port i_req_v / i_req_r  input/output  nstrms  per-stream cacheline request handshake from read control.
REQ-008 SHALL have port o_rsp_v / o_rsp_r  output/input  nstrms  per-stream "cacheline landed in L1" response handshake.
REQ-009 SHALL have port i_rst_v / i_rst_r  input/output  nstrms  per-stream functional reset handshake.
REQ-010 SHALL have port o_ur_re  output  1  URAM read enable pulse.
REQ-011 SHALL have port o_ur_sid / o_ur_clid  output  sid_width / clid_width  URAM read address.
REQ-012 SHALL have port o_wr_en  output  1  L1 BRAM write enable pulse.
REQ-013 SHALL have port o_wr_sid / o_wr_clid  output  sid_width / clid_width  L1 write address.

Function
REQ-014 SHALL hold per stream: clid counter (clid_width bits), inflight bit, pend bit; busy = inflight | pend.
REQ-015 SHALL define eligible[s] = i_req_v[s] & ~busy[s] & ~i_rst_v[s].
REQ-016 SHALL grant at most one eligible stream per cycle, round-robin, priority starting at last grant + 1, wrapping nstrms-1 -> 0.
REQ-017 SHALL assert i_req_r[s] combinationally only in the grant cycle of s; handshake = i_req_v & i_req_r.
REQ-018 SHALL in the grant cycle drive o_ur_re=1, o_ur_sid=s, o_ur_clid=clid[s], set inflight[s], and increment clid[s] modulo ncl (ncl-1 -> 0).
REQ-019 SHALL carry sid/clid through a lat-stage pipeline; exactly lat cycles after grant drive o_wr_en=1 with the same sid/clid.
REQ-020 SHALL in the o_wr_en cycle clear inflight[sid] and set pend[sid].
REQ-021 SHALL drive o_rsp_v[s] = pend[s] (registered); clear pend[s] on o_rsp_v[s] & o_rsp_r[s].
REQ-022 SHALL sustain one grant per cycle across different streams (full throughput, no bubbles).
REQ-023 SHALL assert i_rst_r[s] = ~inflight[s]; on i_rst_v[s] & i_rst_r[s] clear clid[s] and pend[s] in the next cycle.
REQ-024 SHALL, when reset and grant target the same stream in one cycle, perform the reset and not grant (per REQ-015).
REQ-025 SHALL, when reset is requested with an inflight entry, stall i_rst_r until o_wr_en completes; pend set by that write is then cleared by the reset.
REQ-026 SHALL hold o_ur_sid/o_ur_clid/o_wr_sid/o_wr_clid at 0 when their enables are low.

Reset
REQ-027 SHALL on reset low asynchronously clear all clid, inflight, pend, pipeline valids, and RR pointer (next priority = stream 0).
REQ-028 SHALL drive during/after reset: o_rsp_v=0, o_ur_re=0, o_wr_en=0, i_req_r=0, i_rst_r=all-ones, addresses 0.
REQ-029 SHALL drop pipeline contents on reset; no o_wr_en for requests granted before reset.

Structure
REQ-030 SHALL place nstrms, ncl, sid_width, clid_width defaults and a pipeline-entry struct {v, sid, clid} in the shared msb package.
REQ-031 SHALL implement arbitration in one sub-module rr_arb (nstrms-way, one-hot grant, pointer update on grant only).

Verification
REQ-032 Single request stream 5 after reset -> i_req_r[5] same cycle, o_ur_clid=0, o_wr_en at +2 (lat=2), o_rsp_v[5] at +3.
REQ-033 Streams 0,1,2 request together, all rsp_r=1 -> grants 0,1,2 in consecutive cycles, one o_ur_re per cycle.
REQ-034 Stream 3 requests 17 times with ncl=16 -> o_ur_clid sequence 0..15,0; no regrant while o_rsp_v[3] is high.
REQ-035 i_rst_v[7] with inflight entry -> i_rst_r[7]=0 until write, then clid[7]=0, o_rsp_v[7]=0; next grant clid 0.
REQ-036 Reset asserted mid-pipeline -> no o_wr_en follows, all o_rsp_v=0, next grant starts at stream 0.
REQ-037 i_req_v[9] and i_rst_v[9] in the same cycle -> no grant, reset accepted, grant the following cycle.
